// File: rtl/ppu_vram_fill_writer_if.sv
// Bundle of the four PPU-side (port B) VRAM write ports driven by the fill writer.
interface ppu_vram_fill_writer_if;
  logic [10:0] tilram_addr_b;
  logic        tilram_wren_b;
  logic [63:0] tilram_wrdata_b;
  logic [7:0]  tilram_byteena_b;

  logic [11:0] patram_addr_b;
  logic        patram_wren_b;
  logic [63:0] patram_wrdata_b;
  logic [7:0]  patram_byteena_b;

  logic [5:0]  sprram_addr_b;
  logic        sprram_wren_b;
  logic [63:0] sprram_wrdata_b;
  logic [7:0]  sprram_byteena_b;

  logic [8:0]  palram_addr_b;
  logic        palram_wren_b;
  logic [63:0] palram_wrdata_b;
  logic [7:0]  palram_byteena_b;

  modport master (
    output tilram_addr_b, tilram_wren_b, tilram_wrdata_b, tilram_byteena_b,
    output patram_addr_b, patram_wren_b, patram_wrdata_b, patram_byteena_b,
    output sprram_addr_b, sprram_wren_b, sprram_wrdata_b, sprram_byteena_b,
    output palram_addr_b, palram_wren_b, palram_wrdata_b, palram_byteena_b
  );

  modport slave (
    input tilram_addr_b, tilram_wren_b, tilram_wrdata_b, tilram_byteena_b,
    input patram_addr_b, patram_wren_b, patram_wrdata_b, patram_byteena_b,
    input sprram_addr_b, sprram_wren_b, sprram_wrdata_b, sprram_byteena_b,
    input palram_addr_b, palram_wren_b, palram_wrdata_b, palram_byteena_b
  );
endinterface

// File: rtl/ppu_vram_fill_writer.sv
// Sequential VRAM initialiser: writes TILRAM, PATRAM, SPRRAM then PALRAM, one word
// per clock, with either a constant or seed+address data pattern.
module ppu_vram_fill_writer #(
  parameter int          TIL_DEPTH  = 2048,
  parameter int          PAT_DEPTH  = 4096,
  parameter int          SPR_DEPTH  = 40,
  parameter int          PAL_DEPTH  = 512,
  parameter logic [63:0] FILL_VALUE = 64'd12345
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        pattern_sel,
  input  logic [63:0] seed,
  output logic        busy,
  output logic        done,
  ppu_vram_fill_writer_if.master vram
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TIL  = 3'd1;
  localparam logic [2:0] S_PAT  = 3'd2;
  localparam logic [2:0] S_SPR  = 3'd3;
  localparam logic [2:0] S_PAL  = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  localparam logic [11:0] TIL_LAST = 12'(TIL_DEPTH - 1);
  localparam logic [11:0] PAT_LAST = 12'(PAT_DEPTH - 1);
  localparam logic [11:0] SPR_LAST = 12'(SPR_DEPTH - 1);
  localparam logic [11:0] PAL_LAST = 12'(PAL_DEPTH - 1);

  logic [2:0]  state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic        mode_q, mode_d;
  logic [63:0] seed_q, seed_d;

  logic [11:0] last_addr;
  logic [2:0]  next_state;
  logic        writing;
  logic [63:0] data_d;

  logic        busy_q, busy_d, done_q, done_d;
  logic [10:0] til_addr_q, til_addr_d;
  logic [11:0] pat_addr_q, pat_addr_d;
  logic [5:0]  spr_addr_q, spr_addr_d;
  logic [8:0]  pal_addr_q, pal_addr_d;
  logic        til_wren_q, til_wren_d, pat_wren_q, pat_wren_d;
  logic        spr_wren_q, spr_wren_d, pal_wren_q, pal_wren_d;
  logic [63:0] til_data_q, til_data_d, pat_data_q, pat_data_d;
  logic [63:0] spr_data_q, spr_data_d, pal_data_q, pal_data_d;

  // state_q/addr_q describe the write currently on the ports; everything below
  // looks one step ahead so the port registers show the next write.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mode_d     = mode_q;
    seed_d     = seed_q;
    last_addr  = TIL_LAST;
    next_state = S_PAT;
    writing    = 1'b0;
    case (state_q)
      S_TIL: begin last_addr = TIL_LAST; next_state = S_PAT; writing = 1'b1; end
      S_PAT: begin last_addr = PAT_LAST; next_state = S_SPR; writing = 1'b1; end
      S_SPR: begin last_addr = SPR_LAST; next_state = S_PAL; writing = 1'b1; end
      S_PAL: begin last_addr = PAL_LAST; next_state = S_FIN; writing = 1'b1; end
      default: ;
    endcase

    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_TIL;
        addr_d  = '0;
        mode_d  = pattern_sel;
        seed_d  = seed;
      end
    end else if (state_q == S_FIN) begin
      state_d = S_IDLE;
    end else if (writing) begin
      if (abort) begin
        state_d = S_IDLE;
        addr_d  = '0;
      end else if (addr_q == last_addr) begin
        state_d = next_state;
        addr_d  = '0;
      end else begin
        addr_d = addr_q + 12'd1;
      end
    end else begin
      state_d = S_IDLE;
      addr_d  = '0;
    end
  end

  always_comb begin
    data_d     = mode_d ? (seed_d + {52'd0, addr_d}) : FILL_VALUE;
    til_wren_d = (state_d == S_TIL);
    pat_wren_d = (state_d == S_PAT);
    spr_wren_d = (state_d == S_SPR);
    pal_wren_d = (state_d == S_PAL);
    til_addr_d = til_wren_d ? addr_d[10:0] : '0;
    pat_addr_d = pat_wren_d ? addr_d       : '0;
    spr_addr_d = spr_wren_d ? addr_d[5:0]  : '0;
    pal_addr_d = pal_wren_d ? addr_d[8:0]  : '0;
    til_data_d = til_wren_d ? data_d : '0;
    pat_data_d = pat_wren_d ? data_d : '0;
    spr_data_d = spr_wren_d ? data_d : '0;
    pal_data_d = pal_wren_d ? data_d : '0;
    busy_d     = til_wren_d | pat_wren_d | spr_wren_d | pal_wren_d;
    done_d     = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      mode_q     <= 1'b0;
      seed_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      til_addr_q <= '0;
      pat_addr_q <= '0;
      spr_addr_q <= '0;
      pal_addr_q <= '0;
      til_wren_q <= 1'b0;
      pat_wren_q <= 1'b0;
      spr_wren_q <= 1'b0;
      pal_wren_q <= 1'b0;
      til_data_q <= '0;
      pat_data_q <= '0;
      spr_data_q <= '0;
      pal_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mode_q     <= mode_d;
      seed_q     <= seed_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      til_addr_q <= til_addr_d;
      pat_addr_q <= pat_addr_d;
      spr_addr_q <= spr_addr_d;
      pal_addr_q <= pal_addr_d;
      til_wren_q <= til_wren_d;
      pat_wren_q <= pat_wren_d;
      spr_wren_q <= spr_wren_d;
      pal_wren_q <= pal_wren_d;
      til_data_q <= til_data_d;
      pat_data_q <= pat_data_d;
      spr_data_q <= spr_data_d;
      pal_data_q <= pal_data_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  assign vram.tilram_addr_b    = til_addr_q;
  assign vram.tilram_wren_b    = til_wren_q;
  assign vram.tilram_wrdata_b  = til_data_q;
  assign vram.tilram_byteena_b = {8{til_wren_q}};
  assign vram.patram_addr_b    = pat_addr_q;
  assign vram.patram_wren_b    = pat_wren_q;
  assign vram.patram_wrdata_b  = pat_data_q;
  assign vram.patram_byteena_b = {8{pat_wren_q}};
  assign vram.sprram_addr_b    = spr_addr_q;
  assign vram.sprram_wren_b    = spr_wren_q;
  assign vram.sprram_wrdata_b  = spr_data_q;
  assign vram.sprram_byteena_b = {8{spr_wren_q}};
  assign vram.palram_addr_b    = pal_addr_q;
  assign vram.palram_wren_b    = pal_wren_q;
  assign vram.palram_wrdata_b  = pal_data_q;
  assign vram.palram_byteena_b = {8{pal_wren_q}};

endmodule

// File: doc/ppu_vram_fill_writer.md
Name: ppu_vram_fill_writer

Overview:
- Sequential VRAM initialiser on the PPU-facing write ports (port B) of tile, pattern, sprite and palette RAMs.
- On a start pulse it writes every word of the four VRAMs, one write per clock. The order is TILRAM, then PATRAM, then SPRRAM, then PALRAM.
- Data is either a fixed constant or an address-derived value.
- Used to preload known contents so that PPU-Logic and VRAM read paths can be checked on hardware and in simulation.

Parameters:
- TIL_DEPTH, 2048, TILRAM word count (addr 11b).
- PAT_DEPTH, 4096, PATRAM word count (addr 12b).
- SPR_DEPTH, 40, SPRRAM word count (addr 6b).
- PAL_DEPTH, 512, PALRAM word count (addr 9b).
- FILL_VALUE, 64'd12345, constant word used in mode 0.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low).
- start  input  1  single-cycle request to begin a fill; ignored while busy.
- abort  input  1  stop the fill after the current cycle; no done pulse.
- pattern_sel  input  1  0 = FILL_VALUE, 1 = seed + address; sampled with start.
- seed  input  64  base for mode 1; sampled with start.
- busy  output  1  high from the cycle after start until the last write cycle inclusive.
- done  output  1  one-cycle pulse the cycle after the last PALRAM write.
- tilram_addr_b  output  11  TILRAM write address.
- tilram_wren_b  output  1  TILRAM write enable.
- tilram_wrdata_b  output  64  TILRAM write data.
- tilram_byteena_b  output  8  TILRAM byte enables.
- patram_addr_b/wren_b/wrdata_b/byteena_b  output  12/1/64/8  PATRAM write port.
- sprram_addr_b/wren_b/wrdata_b/byteena_b  output  6/1/64/8  SPRRAM write port.
- palram_addr_b/wren_b/wrdata_b/byteena_b  output  9/1/64/8  PALRAM write port.

Behaviour:
- All outputs are registered. Reset values are zero for every address, wren, wrdata, byteena, busy and done.
- FSM states: IDLE, TIL, PAT, SPR, PAL, FIN.
- IDLE -> TIL when start=1.
  - pattern_sel and seed are latched into internal registers in the same cycle.
  - The address counter is cleared.
- Latency: start is sampled in cycle N. The first TILRAM write (addr 0, wren=1) is presented in cycle N+1.
- Each write state asserts exactly one wren per cycle. Only the active RAM's wren is 1; the other three are 0.
- byteena is 8'hFF whenever the corresponding wren is 1, and 8'h00 otherwise.
- The address counter increments by 1 per cycle.
  - At address DEPTH-1 of the current RAM, the FSM moves to the next state and the counter restarts at 0 on the next cycle. There is no idle gap between RAMs.
- Write data:
  - Mode 0: FILL_VALUE.
  - Mode 1: latched seed + address zero-extended to 64b, modulo 2^64. Wrap-around is permitted, e.g. seed 64'hFFFF_FFFF_FFFF_FFFF at addr 1 gives 0.
- Address outputs of inactive RAMs hold 0.
- PAL at address PAL_DEPTH-1 -> FIN. FIN drives done=1 and busy=0 for one cycle, then returns to IDLE.
- Total busy duration = TIL_DEPTH + PAT_DEPTH + SPR_DEPTH + PAL_DEPTH cycles (6696 at defaults).
- start while busy or in FIN is ignored. The latched mode and seed do not change.
- abort=1 in any write state:
  - The current cycle's write still completes.
  - Next cycle: IDLE, all wren 0, busy 0, done stays 0.
  - abort in IDLE or FIN has no effect; a FIN done pulse still occurs.
- start and abort asserted in the same cycle in IDLE: start wins and abort is ignored.
- Reset asserted mid-fill: all outputs are zero immediately (asynchronously) and the FSM returns to IDLE. No resumption after reset deassertion.
- There is no backpressure: the VRAM write ports accept one write per cycle unconditionally.

Test Plan:
- Reset, then a start pulse with pattern_sel=0:
  - Cycle N+1: tilram_addr_b=0, tilram_wren_b=1, wrdata=12345, byteena=8'hFF.
  - 2048 TILRAM writes, then PATRAM addr 0 on the very next cycle.
  - done pulses exactly once, 6697 cycles after start (6696 busy cycles plus FIN).
- pattern_sel=1, seed=64'h100:
  - TILRAM addr 5 data 64'h105.
  - PATRAM addr 4095 data 64'h10FF.
  - SPRRAM addr 39 data 64'h127.
  - PALRAM addr 511 data 64'h2FF.
  - Never two wrens high in the same cycle.
- Mode 1 with seed 64'hFFFF_FFFF_FFFF_FFFE -> TILRAM addr 2 writes 64'h0.
- Assert start again at cycle 100 of a fill with seed changed -> ignored; data continues from the original seed; only one done pulse.
- abort at PATRAM addr 10:
  - The addr 10 write occurs.
  - Next cycle all wren=0 and busy=0; no done pulse.
  - A new start then restarts at TILRAM addr 0.
- rst_n low during SPRRAM writes -> all outputs 0 without waiting for a clock edge. After release, outputs stay idle until a start pulse.
